// File: rtl/fifo_pkg.sv
// Shared constants, operation encoding and parameter-legality helper for the
// synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic bit fifo_levels_ok(input int unsigned addr_width,
                                          input int unsigned af_level,
                                          input int unsigned ae_level);
        int unsigned depth;
        depth = 32'd1 << addr_width;
        return (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: synchronous write port and a registered read port whose output
// register (not the array) is cleared by reset.
module sync_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count, threshold flags and
// one-cycle overflow/underflow pulses.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    if (!fifo_levels_ok(ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $error("sync_fifo: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
    end

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                rd_valid_q, ovf_q, udf_q;
    logic                full, empty, wr_acc, rd_acc;
    fifo_op_e            op;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign wr_acc = W_INC && !full;
    assign rd_acc = R_INC && !empty;
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case (op)
            OP_WRITE: wr_ptr_d = wr_ptr_q + 1'b1;
            OP_READ:  rd_ptr_d = rd_ptr_q + 1'b1;
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: ;
        endcase
        // Extra pointer bit makes the difference span 0..DEPTH unambiguously.
        count_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
            ovf_q      <= W_INC && full;
            udf_q      <= R_INC && empty;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .we_i    (wr_acc && RST),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (WR_DATA),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (RD_DATA)
    );

    assign RD_VALID     = rd_valid_q;
    assign FULL         = full;
    assign EMPTY        = empty;
    assign ALMOST_FULL  = (count_q >= AF_C);
    assign ALMOST_EMPTY = (count_q <= AE_C);
    assign COUNT        = count_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo at DATA_WIDTH=8, ADDR_WIDTH=3,
// AF_LEVEL=6, AE_LEVEL=1.
module tb_sync_fifo;

    logic       CLK = 1'b0;
    logic       RST;
    logic       W_INC;
    logic [7:0] WR_DATA;
    logic       R_INC;
    logic [7:0] RD_DATA;
    logic       RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
    logic [3:0] COUNT;
    logic       OVERFLOW, UNDERFLOW;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_word;

    sync_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .AF_LEVEL   (6),
        .AE_LEVEL   (1)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .W_INC        (W_INC),
        .WR_DATA      (WR_DATA),
        .R_INC        (R_INC),
        .RD_DATA      (RD_DATA),
        .RD_VALID     (RD_VALID),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0; W_INC = 1'b0; R_INC = 1'b0; WR_DATA = '0;
        tick(); tick();
        RST = 1'b1;
        check("rst_count", COUNT, 0);
        check("rst_empty", EMPTY, 1);
        check("rst_full", FULL, 0);
        check("rst_ae", ALMOST_EMPTY, 1);
        check("rst_af", ALMOST_FULL, 0);
        check("rst_rdvalid", RD_VALID, 0);
        check("rst_rddata", RD_DATA, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_udf", UNDERFLOW, 0);

        // Fill with 0x01..0x08.
        for (int i = 1; i <= 8; i++) begin
            W_INC = 1'b1; WR_DATA = 8'(i);
            tick();
            check("fill_count", COUNT, i);
            check("fill_af", ALMOST_FULL, (i >= 6) ? 1 : 0);
            check("fill_full", FULL, (i == 8) ? 1 : 0);
            check("fill_ae", ALMOST_EMPTY, (i <= 1) ? 1 : 0);
            check("fill_empty", EMPTY, 0);
        end

        W_INC = 1'b1; WR_DATA = 8'hAA;
        tick();
        W_INC = 1'b0;
        check("ovf_pulse", OVERFLOW, 1);
        check("ovf_count", COUNT, 8);
        tick();
        check("ovf_once", OVERFLOW, 0);

        R_INC = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("drain_valid", RD_VALID, 1);
            check("drain_data", RD_DATA, i);
            check("drain_count", COUNT, 8 - i);
        end
        R_INC = 1'b0;
        tick();
        check("idle_valid", RD_VALID, 0);
        check("idle_hold", RD_DATA, 8'h08);
        check("idle_empty", EMPTY, 1);

        // Underflow, then simultaneous read/write on empty.
        R_INC = 1'b1;
        tick();
        R_INC = 1'b0;
        check("udf_pulse", UNDERFLOW, 1);
        check("udf_valid", RD_VALID, 0);
        check("udf_hold", RD_DATA, 8'h08);
        tick();
        check("udf_once", UNDERFLOW, 0);
        W_INC = 1'b1; R_INC = 1'b1; WR_DATA = 8'h55;
        tick();
        W_INC = 1'b0; R_INC = 1'b0;
        check("rw_empty_count", COUNT, 1);
        check("rw_empty_udf", UNDERFLOW, 1);
        check("rw_empty_valid", RD_VALID, 0);
        exp_q.push_back(8'h55);

        // Bring occupancy to 4, then stream 20 cycles across pointer wrap.
        for (int i = 0; i < 3; i++) begin
            W_INC = 1'b1; WR_DATA = 8'h10 + 8'(i);
            exp_q.push_back(WR_DATA);
            tick();
        end
        check("pre_stream_count", COUNT, 4);
        for (int k = 0; k < 20; k++) begin
            W_INC = 1'b1; R_INC = 1'b1; WR_DATA = 8'h20 + 8'(k);
            exp_q.push_back(WR_DATA);
            tick();
            exp_word = exp_q.pop_front();
            check("stream_count", COUNT, 4);
            check("stream_valid", RD_VALID, 1);
            check("stream_data", RD_DATA, exp_word);
            check("stream_flags", {OVERFLOW, UNDERFLOW}, 0);
        end
        W_INC = 1'b0; R_INC = 1'b0;

        for (int i = 0; i < 4; i++) begin
            W_INC = 1'b1; WR_DATA = 8'h40 + 8'(i);
            exp_q.push_back(WR_DATA);
            tick();
        end
        W_INC = 1'b0;
        check("refill_count", COUNT, 8);
        check("refill_full", FULL, 1);

        // Read+write while full: read wins, write rejected.
        W_INC = 1'b1; R_INC = 1'b1; WR_DATA = 8'hEE;
        tick();
        W_INC = 1'b0;
        exp_word = exp_q.pop_front();
        check("rw_full_data", RD_DATA, exp_word);
        check("rw_full_valid", RD_VALID, 1);
        check("rw_full_count", COUNT, 7);
        check("rw_full_ovf", OVERFLOW, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_word = exp_q.pop_front();
            check("rw_full_drain", RD_DATA, exp_word);
        end
        R_INC = 1'b0;
        tick();
        check("rw_full_empty", EMPTY, 1);

        // Reset mid-operation with a concurrent write.
        for (int i = 0; i < 5; i++) begin
            W_INC = 1'b1; WR_DATA = 8'h60 + 8'(i);
            tick();
        end
        check("prerst_count", COUNT, 5);
        RST = 1'b0; W_INC = 1'b1; WR_DATA = 8'h99;
        tick();
        RST = 1'b1; W_INC = 1'b0;
        check("midrst_count", COUNT, 0);
        check("midrst_empty", EMPTY, 1);
        check("midrst_valid", RD_VALID, 0);
        check("midrst_data", RD_DATA, 0);
        R_INC = 1'b1;
        tick();
        R_INC = 1'b0;
        check("postrst_udf", UNDERFLOW, 1);
        check("postrst_valid", RD_VALID, 0);
        check("postrst_count", COUNT, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of each stored word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3: DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter AF_LEVEL, default 6: almost-full threshold in words, legal range 1..DEPTH.
REQ-004 The block SHALL have parameter AE_LEVEL, default 1: almost-empty threshold in words, legal range 0..DEPTH-1.
REQ-005 The block SHALL run on one clock with a synchronous, active-low reset, using these ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous active-low reset.
- W_INC  in  1  write request.
- WR_DATA  in  DATA_WIDTH  write data.
- R_INC  in  1  read request.
- RD_DATA  out  DATA_WIDTH  registered read data.
- RD_VALID  out  1  one-cycle pulse, RD_DATA holds a newly read word.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL.
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL.
- COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- OVERFLOW  out  1  one-cycle pulse, rejected write.
- UNDERFLOW  out  1  one-cycle pulse, rejected read.

Function
REQ-006 Write and read pointers SHALL be ADDR_WIDTH+1-bit binary counters that wrap from 2**(ADDR_WIDTH+1)-1 to 0; the low ADDR_WIDTH bits address memory.
REQ-007 A write SHALL be accepted on a rising edge when W_INC=1 and FULL=0: WR_DATA is stored at the write address and the write pointer increments.
REQ-008 A read SHALL be accepted on a rising edge when R_INC=1 and EMPTY=0: the word at the read address loads RD_DATA, RD_VALID=1 for the next cycle, and the read pointer increments.
REQ-009 Read latency SHALL be one cycle from accepted R_INC to RD_VALID; RD_DATA SHALL hold its value when no read is accepted.
REQ-010 FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY SHALL be decoded from the registered COUNT only, never from same-cycle W_INC/R_INC.
REQ-011 COUNT SHALL change by +1 (write only accepted), -1 (read only accepted), or 0 (both or neither accepted).
REQ-012 Simultaneous W_INC and R_INC when 0 < COUNT < DEPTH SHALL accept both, leave COUNT unchanged, and advance both pointers.
REQ-013 Simultaneous W_INC and R_INC when FULL SHALL accept the read, reject the write, give COUNT = DEPTH-1, and pulse OVERFLOW.
REQ-014 Simultaneous W_INC and R_INC when EMPTY SHALL accept the write, reject the read, give COUNT = 1, and pulse UNDERFLOW; there is no same-cycle bypass.
REQ-015 OVERFLOW SHALL be 1 for exactly the cycle after each edge where W_INC=1 and FULL=1; UNDERFLOW SHALL behave the same for R_INC=1 and EMPTY=1.
REQ-016 Rejected operations SHALL alter neither memory, the pointers, COUNT, nor RD_DATA.

Reset
REQ-017 While RST=0 at a rising edge, the block SHALL clear both pointers, COUNT, RD_DATA, RD_VALID, OVERFLOW and UNDERFLOW, which gives EMPTY=1 and FULL=0.
REQ-018 After reset, ALMOST_EMPTY SHALL be 1 and ALMOST_FULL SHALL be 0 (for AF_LEVEL >= 1).
REQ-019 Reset SHALL take priority over W_INC and R_INC in the same cycle; a reset during operation discards all stored words.
REQ-020 Memory contents SHALL NOT be reset; unread data is never observable after reset.

Structure
REQ-021 A shared package fifo_pkg SHALL hold the default DATA_WIDTH/ADDR_WIDTH constants and the threshold-legality checking function.
REQ-022 Storage SHALL be one sub-module, sync_fifo_mem: a 2**ADDR_WIDTH x DATA_WIDTH array with a synchronous write port and a registered read port.
REQ-023 Elaboration SHALL fail for AF_LEVEL or AE_LEVEL outside their legal ranges.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, AF=6, AE=1)
REQ-024 Reset, then write 0x01..0x08 -> COUNT goes 1..8; ALMOST_FULL rises at COUNT=6; FULL rises at COUNT=8; ALMOST_EMPTY falls at COUNT=2.
REQ-025 With the FIFO full, W_INC with 0xAA -> OVERFLOW pulses once; COUNT stays 8; reading all 8 words returns 0x01..0x08, each with one RD_VALID pulse.
REQ-026 With the FIFO empty, R_INC -> UNDERFLOW pulses, RD_VALID stays 0, RD_DATA unchanged; then W_INC and R_INC together -> write accepted, COUNT=1, UNDERFLOW pulses.
REQ-027 With COUNT=4, hold W_INC and R_INC for 20 cycles with an incrementing pattern -> COUNT stays 4, data order is preserved across pointer wrap, no flag pulses.
REQ-028 With COUNT=8, W_INC and R_INC together -> read returns the oldest word, COUNT=7, OVERFLOW pulses, and the rejected data is never read back.
REQ-029 Assert RST=0 with COUNT=5 and W_INC=1 -> next cycle COUNT=0, EMPTY=1, RD_VALID=0, and a subsequent read is rejected with UNDERFLOW.
